// File: rtl/key_repeat_if.sv
// Key-repeat bus: held-key input, companion timer handshake and the
// valid/ready keystroke output stream, grouped for the key_repeat block.
interface key_repeat_if;
    logic       key_down;
    logic [7:0] key_code;
    logic       timer_finished;
    logic       timer_clear;
    logic       timer_enabled;
    logic       out_valid;
    logic [7:0] out_code;
    logic       out_ready;

    // master: the key_repeat block itself
    modport master (
        input  key_down,
        input  key_code,
        input  timer_finished,
        input  out_ready,
        output timer_clear,
        output timer_enabled,
        output out_valid,
        output out_code
    );

    // slave: keyboard scanner, timer and downstream consumer side
    modport slave (
        output key_down,
        output key_code,
        output timer_finished,
        output out_ready,
        input  timer_clear,
        input  timer_enabled,
        input  out_valid,
        input  out_code
    );
endinterface

// File: rtl/key_repeat.sv
// Typematic key repeater: emits a keystroke on press (or code change), then,
// when KEY_REPEAT_AUTOREPEAT_EN is defined, repeats it after DELAY_TICKS
// timer ticks and every RATE_TICKS ticks thereafter. Without the macro,
// exactly one keystroke is emitted per press or code change and the
// companion timer is never enabled. Output is a single-entry valid/ready
// slot; emissions arriving while an unaccepted offer is pending are dropped.
module key_repeat #(
    parameter int unsigned DELAY_TICKS = 25,
    parameter int unsigned RATE_TICKS  = 3
) (
    input  logic         clk,
    input  logic         reset,
    key_repeat_if.master bus
);

`ifdef KEY_REPEAT_AUTOREPEAT_EN
    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
    localparam logic TIMER_ON = 1'b1;
`else
    typedef enum logic [1:0] {IDLE, DELAY} state_t;
    localparam logic TIMER_ON = 1'b0;
`endif

    localparam logic [7:0] DELAY_LOAD = 8'(DELAY_TICKS - 1);
    localparam logic [7:0] RATE_LOAD  = 8'(RATE_TICKS - 1);

    state_t     state;
    logic [7:0] count;
    logic [7:0] held_code;

    logic       in_hold;
    logic       press;
    logic       rep_emit;
    logic       emit;
    logic [7:0] emit_code;
    logic       accept;
    logic       slot_free;
`ifdef KEY_REPEAT_AUTOREPEAT_EN
    logic       tick;
`else
    logic       unused_cfg;
    assign unused_cfg = ^{bus.timer_finished, count, RATE_LOAD};
`endif

    // Decode press/code-change, tick-driven repeat and output slot status
    always_comb begin
        in_hold   = (state != IDLE) && bus.key_down && (bus.key_code == held_code);
        press     = bus.key_down && !in_hold;
        accept    = bus.out_valid && bus.out_ready;
        slot_free = !bus.out_valid || bus.out_ready;
`ifdef KEY_REPEAT_AUTOREPEAT_EN
        tick      = bus.timer_finished && bus.timer_enabled;
        rep_emit  = in_hold && tick && (count == '0);
`else
        rep_emit  = 1'b0;
`endif
        emit      = press || rep_emit;
        emit_code = press ? bus.key_code : held_code;
    end

    // State machine, delay/rate counter and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            count             <= '0;
            held_code         <= '0;
            bus.out_valid     <= 1'b0;
            bus.out_code      <= '0;
            bus.timer_clear   <= 1'b0;
            bus.timer_enabled <= 1'b0;
        end else begin
            bus.timer_clear <= 1'b0;

            // A release suppresses any emission because press and rep_emit
            // both require key_down; the pending offer is left untouched.
            if (emit && slot_free) begin
                bus.out_valid <= 1'b1;
                bus.out_code  <= emit_code;
            end else if (accept) begin
                bus.out_valid <= 1'b0;
            end

            if (!bus.key_down) begin
                state             <= IDLE;
                bus.timer_enabled <= 1'b0;
            end else if (press) begin
                held_code         <= bus.key_code;
                count             <= DELAY_LOAD;
                bus.timer_clear   <= 1'b1;
                bus.timer_enabled <= TIMER_ON;
                state             <= DELAY;
            end
`ifdef KEY_REPEAT_AUTOREPEAT_EN
            else if (tick) begin
                if (count != '0) begin
                    count <= count - 8'd1;
                end else begin
                    count <= RATE_LOAD;
                    state <= REPEAT;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_key_repeat.sv
// Self-checking bench for key_repeat (DELAY_TICKS=3, RATE_TICKS=2) with a
// behavioural companion timer. Expectations follow KEY_REPEAT_AUTOREPEAT_EN.
module tb_key_repeat;

`ifdef KEY_REPEAT_AUTOREPEAT_EN
    localparam logic AR = 1'b1;
`else
    localparam logic AR = 1'b0;
`endif

    logic clk;
    logic reset;
    key_repeat_if bus ();

    key_repeat #(.DELAY_TICKS(3), .RATE_TICKS(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Timer model: pulses once every 4 enabled cycles after a clear
    logic [1:0] tm;
    always @(posedge clk) begin
        if (bus.timer_clear || !bus.timer_enabled) tm <= 2'd0;
        else                                       tm <= tm + 2'd1;
    end
    assign bus.timer_finished = bus.timer_enabled && !bus.timer_clear && (tm == 2'd3);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         rel;
        logic [7:0] code;
    } acc_t;

    acc_t log_q[$];
    acc_t exp_q[$];
    int   base   = 0;
    bit   mon_on = 1'b0;

    // Acceptance monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (mon_on && bus.out_valid && bus.out_ready)
            log_q.push_back('{cyc - base, bus.out_code});
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_scn();
        log_q.delete();
        exp_q.delete();
        base   = cyc;
        mon_on = 1'b1;
    endtask

    task automatic check_log(input string name);
        int n;
        chk({name, " count"}, log_q.size(), exp_q.size());
        n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s[%0d] cycle", name, i), log_q[i].rel, exp_q[i].rel);
            chk($sformatf("%s[%0d] code", name, i), {24'd0, log_q[i].code}, {24'd0, exp_q[i].code});
        end
    endtask

    typedef struct {
        logic       rst;
        logic       kd;
        logic [7:0] code;
        logic       rdy;
        logic       ev;
        logic [7:0] ec;
        logic       eclr;
        logic       een;
    } vec_t;

    vec_t vt[18];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit held_ok;
        reset         = 1'b1;
        bus.key_down  = 1'b0;
        bus.key_code  = 8'h00;
        bus.out_ready = 1'b1;

        //        rst   kd    code   rdy   valid code   clr   en
        vt[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        vt[1]  = '{1'b1, 1'b1, 8'h41, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        vt[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        vt[3]  = '{1'b0, 1'b1, 8'h41, 1'b0, 1'b1, 8'h41, 1'b1, AR};
        vt[4]  = '{1'b0, 1'b1, 8'h41, 1'b0, 1'b1, 8'h41, 1'b0, AR};
        vt[5]  = '{1'b0, 1'b1, 8'h41, 1'b1, 1'b0, 8'h41, 1'b0, AR};
        vt[6]  = '{1'b0, 1'b1, 8'h42, 1'b1, 1'b1, 8'h42, 1'b1, AR};
        vt[7]  = '{1'b0, 1'b1, 8'h42, 1'b1, 1'b0, 8'h42, 1'b0, AR};
        vt[8]  = '{1'b0, 1'b0, 8'h42, 1'b1, 1'b0, 8'h42, 1'b0, 1'b0};
        vt[9]  = '{1'b0, 1'b1, 8'h43, 1'b1, 1'b1, 8'h43, 1'b1, AR};
        vt[10] = '{1'b0, 1'b0, 8'h43, 1'b0, 1'b1, 8'h43, 1'b0, 1'b0};
        vt[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h43, 1'b0, 1'b0};
        vt[12] = '{1'b0, 1'b1, 8'h44, 1'b0, 1'b1, 8'h43, 1'b1, AR};
        vt[13] = '{1'b0, 1'b1, 8'h44, 1'b1, 1'b0, 8'h43, 1'b0, AR};
        vt[14] = '{1'b0, 1'b1, 8'h45, 1'b1, 1'b1, 8'h45, 1'b1, AR};
        vt[15] = '{1'b0, 1'b1, 8'h46, 1'b1, 1'b1, 8'h46, 1'b1, AR};
        vt[16] = '{1'b0, 1'b0, 8'h46, 1'b1, 1'b0, 8'h46, 1'b0, 1'b0};
        vt[17] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};

        for (int i = 0; i < 18; i++) begin
            reset         = vt[i].rst;
            bus.key_down  = vt[i].kd;
            bus.key_code  = vt[i].code;
            bus.out_ready = vt[i].rdy;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d out_valid", i), {31'd0, bus.out_valid}, {31'd0, vt[i].ev});
            chk($sformatf("vec%0d out_code", i), {24'd0, bus.out_code}, {24'd0, vt[i].ec});
            chk($sformatf("vec%0d timer_clear", i), {31'd0, bus.timer_clear}, {31'd0, vt[i].eclr});
            chk($sformatf("vec%0d timer_enabled", i), {31'd0, bus.timer_enabled}, {31'd0, vt[i].een});
        end

        reset         = 1'b0;
        bus.out_ready = 1'b1;
        run(3);

        // Hold 0x41 for 40 cycles
        start_scn();
        bus.key_down = 1'b1;
        bus.key_code = 8'h41;
        run(40);
        bus.key_down = 1'b0;
        run(20);
        exp_q.push_back('{1, 8'h41});
`ifdef KEY_REPEAT_AUTOREPEAT_EN
        exp_q.push_back('{14, 8'h41});
        exp_q.push_back('{22, 8'h41});
        exp_q.push_back('{30, 8'h41});
        exp_q.push_back('{38, 8'h41});
`endif
        check_log("hold40");

        // Downstream stalled for 30 cycles: offer held, repeats dropped
        start_scn();
        bus.out_ready = 1'b0;
        bus.key_down  = 1'b1;
        bus.key_code  = 8'h41;
        run(1);
        held_ok = 1'b1;
        repeat (29) begin
            @(negedge clk);
            if (!(bus.out_valid === 1'b1 && bus.out_code === 8'h41)) held_ok = 1'b0;
            @(posedge clk);
            #1;
        end
        chk("stall offer held", {31'd0, held_ok}, 32'd1);
        bus.out_ready = 1'b1;
        run(10);
        bus.key_down = 1'b0;
        run(20);
        exp_q.push_back('{30, 8'h41});
`ifdef KEY_REPEAT_AUTOREPEAT_EN
        exp_q.push_back('{38, 8'h41});
`endif
        check_log("stall");

        // Release on the tick that would produce the first repeat
        start_scn();
        bus.key_down = 1'b1;
        bus.key_code = 8'h41;
        run(13);
        bus.key_down = 1'b0;
        run(1);
        @(negedge clk);
        chk("release-tick out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("release-tick timer_enabled", {31'd0, bus.timer_enabled}, 32'd0);
        run(20);
        exp_q.push_back('{1, 8'h41});
        check_log("release-tick");

        // Code change 0x41 -> 0x42 in REPEAT
        start_scn();
        bus.key_down = 1'b1;
        bus.key_code = 8'h41;
        run(16);
        bus.key_code = 8'h42;
        run(1);
        @(negedge clk);
        chk("change timer_clear", {31'd0, bus.timer_clear}, 32'd1);
        chk("change out_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("change out_code", {24'd0, bus.out_code}, 32'h42);
        run(15);
        bus.key_down = 1'b0;
        run(20);
        exp_q.push_back('{1, 8'h41});
`ifdef KEY_REPEAT_AUTOREPEAT_EN
        exp_q.push_back('{14, 8'h41});
`endif
        exp_q.push_back('{17, 8'h42});
`ifdef KEY_REPEAT_AUTOREPEAT_EN
        exp_q.push_back('{30, 8'h42});
`endif
        check_log("change");

        // Reset in REPEAT with an offer pending; held key re-emits afterwards
        start_scn();
        bus.out_ready = 1'b0;
        bus.key_down  = 1'b1;
        bus.key_code  = 8'h41;
        run(15);
        reset = 1'b1;
        run(1);
        @(negedge clk);
        chk("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("reset timer_enabled", {31'd0, bus.timer_enabled}, 32'd0);
        chk("reset timer_clear", {31'd0, bus.timer_clear}, 32'd0);
        chk("reset out_code", {24'd0, bus.out_code}, 32'h00);
        @(posedge clk);
        #1;
        reset = 1'b0;
        run(1);
        @(negedge clk);
        chk("post-reset out_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("post-reset out_code", {24'd0, bus.out_code}, 32'h41);
        chk("post-reset timer_clear", {31'd0, bus.timer_clear}, 32'd1);
        chk("post-reset timer_enabled", {31'd0, bus.timer_enabled}, {31'd0, AR});
        bus.out_ready = 1'b1;
        bus.key_down  = 1'b0;
        run(5);
        mon_on = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/key_repeat.md
KEY_REPEAT -- requirements
Module: key_repeat

Interface
REQ-001 SHALL have parameter DELAY_TICKS, default 25: timer ticks from first keystroke to first repeat; legal range 1..255.
REQ-002 SHALL have parameter RATE_TICKS, default 3: timer ticks between successive repeats; legal range 1..255.
REQ-003 SHALL have port clk  input  1: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-005 SHALL have port key_down  input  1: level, high while a key is held.
REQ-006 SHALL have port key_code  input  8: code of the held key; valid while key_down is high.
REQ-007 SHALL have port timer_finished  input  1: period flag from the companion timer.
REQ-008 SHALL have port timer_clear  output  1: restarts the companion timer period.
REQ-009 SHALL have port timer_enabled  output  1: lets the companion timer count.
REQ-010 SHALL have port out_valid  output  1: a keystroke is offered downstream.
REQ-011 SHALL have port out_code  output  8: code of the offered keystroke.
REQ-012 SHALL have port out_ready  input  1: downstream accepts when out_valid and out_ready are both high.

Function
REQ-013 SHALL implement states IDLE, DELAY and REPEAT.
REQ-014 IDLE, key_down high: SHALL latch key_code, emit it (out_valid high next cycle), pulse timer_clear for one cycle, load the counter with DELAY_TICKS-1, and go to DELAY.
REQ-015 SHALL define a tick as timer_finished high while timer_enabled is high.
REQ-016 SHALL hold timer_enabled high in DELAY and REPEAT, and low in IDLE.
REQ-017 DELAY/REPEAT: each tick with counter nonzero SHALL decrement the counter.
REQ-018 DELAY/REPEAT: a tick with counter zero SHALL emit the latched code, load RATE_TICKS-1, and go to (or stay in) REPEAT.
REQ-019 DELAY/REPEAT, key_down low: SHALL go to IDLE and suppress any emission in that cycle, even if it coincides with a tick.
REQ-020 DELAY/REPEAT, key_down high and key_code different from the latched code: SHALL behave as REQ-014 (new code emitted, delay restarted).
REQ-021 out_valid SHALL stay high with out_code stable until accepted.
REQ-022 An accepted offer with no new emission in the same cycle SHALL drop out_valid on the next cycle.
REQ-023 An emission coinciding with acceptance SHALL keep out_valid high and present the new code next cycle.
REQ-024 An emission while out_valid is high and not accepted (overrun) SHALL be dropped; the counter reload and state transition still occur.
REQ-025 A pending offer SHALL survive key release and remain until accepted.
REQ-026 The counter SHALL be 8 bits and SHALL never wrap below zero.

Reset
REQ-027 Reset high SHALL, on the next edge: state=IDLE, counter=0, out_valid=0, out_code=0, timer_clear=0, timer_enabled=0; a pending offer is discarded.
REQ-028 Reset SHALL take priority over every other input in the same cycle, including mid-DELAY or mid-REPEAT.
REQ-029 After reset is released, a key already held SHALL be treated as a new press.

Configuration
REQ-030 Macro KEY_REPEAT_AUTOREPEAT_EN defined: full behaviour as specified above.
REQ-031 Macro KEY_REPEAT_AUTOREPEAT_EN undefined: REPEAT is removed, and DELAY waits only for key release or code change with no tick-driven emissions; timer_enabled stays 0; exactly one keystroke is emitted per press or code change.

Verification
REQ-032 Bench setup for all scenarios: DELAY_TICKS=3, RATE_TICKS=2; timer model pulses timer_finished once every 4 enabled cycles after clear; out_ready held high unless stated.
REQ-033 Hold key 0x41 for 40 cycles -> required response: 0x41 on the cycle after the press, then at tick 3, then every 2 ticks; none after release.
REQ-034 Press 0x41, hold out_ready low for 30 cycles -> required response: out_valid held with 0x41 throughout, repeats dropped, one acceptance when ready rises.
REQ-035 Release the key on the same cycle as the tick that would repeat -> required response: no emission, and IDLE on the next cycle.
REQ-036 Change key_code from 0x41 to 0x42 mid-REPEAT -> required response: 0x42 emitted next cycle, timer_clear pulses, first 0x42 repeat 3 ticks later.
REQ-037 Assert reset mid-REPEAT with an offer pending -> required response: out_valid=0 and timer_enabled=0 next cycle; key still held after release re-emits.
